// File: rtl/div_pkg.sv
// Shared widths, divide-by-zero pattern and a behavioural
// reference model for the pipelined restoring divider.
package div_pkg;

  localparam int DIV_N_DEF = 8;
  localparam int DIV_M_DEF = 4;

  localparam logic [63:0] DIV_Q_DZ = '1;

  typedef struct packed {
    logic [DIV_N_DEF-1:0] q;
    logic [DIV_M_DEF-1:0] r;
    logic                 dz;
  } div_res_t;

  function automatic div_res_t div_ref(
    input logic [DIV_N_DEF-1:0] dividend,
    input logic [DIV_M_DEF-1:0] divisor
  );
    div_res_t             res;
    logic [DIV_N_DEF-1:0] dvs;
    dvs = {{(DIV_N_DEF-DIV_M_DEF){1'b0}}, divisor};
    if (divisor == '0) begin
      res.q  = DIV_Q_DZ[DIV_N_DEF-1:0];
      res.r  = '0;
      res.dz = 1'b1;
    end else begin
      res.q  = dividend / dvs;
      res.r  = DIV_M_DEF'(dividend % dvs);
      res.dz = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_cell.sv
// One restoring-division stage: shift in a dividend bit,
// compare/subtract the divisor, register the partial state.
module div_cell #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_i,
  input  logic [N-1:0] dvd_i,
  input  logic [M-1:0] dvs_i,
  input  logic [N-1:0] quo_i,
  input  logic [M-1:0] rem_i,
  input  logic         dz_i,
  output logic         v_o,
  output logic [N-1:0] dvd_o,
  output logic [M-1:0] dvs_o,
  output logic [N-1:0] quo_o,
  output logic [M-1:0] rem_o,
  output logic         dz_o
);

  logic [M:0]   t;
  logic [M:0]   diff;
  logic [M:0]   nxt;
  logic         ge;

  logic         v_d,   v_q;
  logic [N-1:0] dvd_d, dvd_q;
  logic [M-1:0] dvs_d, dvs_q;
  logic [N-1:0] quo_d, quo_q;
  logic [M-1:0] rem_d, rem_q;
  logic         dz_d,  dz_q;

  always_comb begin
    t     = {rem_i, dvd_i[N-1-K]};
    diff  = t - {1'b0, dvs_i};
    ge    = (t >= {1'b0, dvs_i});
    nxt   = ge ? diff : t;
    v_d   = v_i;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d  = dz_q;
    // bubbles leave the previous operation's data untouched
    if (v_i) begin
      dvd_d          = dvd_i;
      dvs_d          = dvs_i;
      quo_d          = quo_i;
      quo_d[N-1-K]   = ge;
      rem_d          = nxt[M-1:0];
      dz_d           = dz_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      v_q   <= v_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end

  always @(posedge clk) begin
    if (!rst && v_i && !dz_i)
      assert (nxt < {1'b0, dvs_i});
  end

  assign v_o   = v_q;
  assign dvd_o = dvd_q;
  assign dvs_o = dvs_q;
  assign quo_o = quo_q;
  assign rem_o = rem_q;
  assign dz_o  = dz_q;

endmodule

// File: rtl/div_man.sv
// Pipelined unsigned restoring divider: N stages, one
// quotient bit per stage, registered result with res_rdy.
module div_man
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEF,
  parameter int M = DIV_M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         res_rdy,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero
);

  logic [N:0]        v;
  logic [N:0]        dz;
  logic [N:0][N-1:0] dvd;
  logic [N:0][N-1:0] quo;
  logic [N:0][M-1:0] dvs;
  logic [N:0][M-1:0] rem;

  assign v[0]   = data_rdy;
  assign dvd[0] = dividend;
  assign dvs[0] = divisor;
  assign quo[0] = '0;
  assign rem[0] = '0;
  assign dz[0]  = (divisor == '0);

  for (genvar k = 0; k < N; k++) begin : g_stage
    div_cell #(
      .N (N),
      .M (M),
      .K (k)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .v_i   (v[k]),
      .dvd_i (dvd[k]),
      .dvs_i (dvs[k]),
      .quo_i (quo[k]),
      .rem_i (rem[k]),
      .dz_i  (dz[k]),
      .v_o   (v[k+1]),
      .dvd_o (dvd[k+1]),
      .dvs_o (dvs[k+1]),
      .quo_o (quo[k+1]),
      .rem_o (rem[k+1]),
      .dz_o  (dz[k+1])
    );
  end

  logic         res_rdy_d,   res_rdy_q;
  logic [N-1:0] quotient_d,  quotient_q;
  logic [M-1:0] remainder_d, remainder_q;
  logic         div_zero_d,  div_zero_q;

  always_comb begin
    res_rdy_d   = v[N];
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    if (v[N]) begin
      quotient_d  = dz[N] ? DIV_Q_DZ[N-1:0] : quo[N];
      remainder_d = dz[N] ? '0 : rem[N];
      div_zero_d  = dz[N];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_rdy_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      res_rdy_q   <= res_rdy_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // the last stage still carries its operands, so check it
  if (N == DIV_N_DEF && M == DIV_M_DEF) begin : g_chk
    div_res_t exp_r;
    always_comb exp_r = div_ref(dvd[N], dvs[N]);
    always @(posedge clk) begin
      if (!rst && v[N])
        assert (exp_r == {quotient_d, remainder_d, dz[N]});
    end
  end

  assign res_rdy   = res_rdy_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
